// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with a hardware
// zero register, optional write-to-read bypass and a post-reset clear engine.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   we, wa, wd   : write port (enable, address, data)
//   rs           : NUM_READ packed read addresses, port i at rs[i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata        : NUM_READ packed read data, port i at rdata[i*DATA_WIDTH +: DATA_WIDTH]
//   ready        : clear finished, file in normal operation
//   wr_drop      : one-cycle pulse, a write was discarded last cycle while not ready
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]          wd,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rs,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic                           ready,
    output logic                           wr_drop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic                    wr_drop_q, wr_drop_d;

    logic [DATA_WIDTH-1:0]   rf_q [DEPTH];

    // Single array write port shared by the clear engine and the write-back path.
    logic                    rf_we;
    logic [ADDR_WIDTH-1:0]   rf_wa;
    logic [DATA_WIDTH-1:0]   rf_wd;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Array storage; deliberately untouched on the reset edge itself.
    always_ff @(posedge clk) begin
        if (!rst && rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // Next-state and array write selection
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_drop_d = 1'b0;
        rf_we     = 1'b0;
        rf_wa     = wa;
        rf_wd     = wd;
        unique case (state_q)
            CLEAR: begin
                rf_we     = 1'b1;
                rf_wa     = clr_idx_q;
                rf_wd     = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                wr_drop_d = we;
                // Leave on the last index so no extra cycle is spent.
                if (clr_idx_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (we && !((ZERO_REG != 0) && (wa == '0))) begin
                    rf_we = 1'b1;
                end
            end
        endcase
    end

    // Outputs; each read port decodes its own address independently.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        ra      = '0;
        rdata   = '0;
        ready   = (state_q == RUN);
        wr_drop = wr_drop_q;
        for (int i = 0; i < NUM_READ; i++) begin
            ra = rs[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (state_q == CLEAR) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS != 0) && we && (wa == ra)) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = wd;
            end else begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[ra];
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the 2-read/1-write core register file.
- Adds configurable read-port count, optional write-to-read bypass, hardware zero register, and a sequential clear engine that zeroes every entry after reset.
- Sits in the decode/register-read stage.
- Write-back drives the write port. Decode/issue drives the read ports and waits for `ready` before issuing.

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_READ, 2, number of read ports; legal range 1..4.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- wa  input  ADDR_WIDTH  write address.
- wd  input  DATA_WIDTH  write data.
- rs  input  NUM_READ*ADDR_WIDTH  read addresses; port i = rs[i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  output  NUM_READ*DATA_WIDTH  read data; port i = rdata[i*DATA_WIDTH +: DATA_WIDTH].
- ready  output  1  high when clear is complete and the file is in normal operation.
- wr_drop  output  1  one-cycle pulse: a write was discarded one cycle earlier because `ready` was low.

Behaviour:
- Decided: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: CLEAR, RUN. A clear counter `clr_idx` is ADDR_WIDTH bits wide.
- Reset (any rising edge with rst=1):
  - state <= CLEAR, clr_idx <= 0.
  - ready <= 0, wr_drop <= 0.
  - Array contents are not touched on the reset edge itself.
- CLEAR (rst=0):
  - Each edge: rf[clr_idx] <= 0 and clr_idx <= clr_idx+1.
  - On the edge where clr_idx == DEPTH-1: state <= RUN and ready <= 1.
  - Hence ready rises on the DEPTH-th rising edge after rst deasserts (edge 32 for the default).
  - A write request (we=1) in CLEAR is discarded; wr_drop <= 1 for exactly the next cycle.
- RUN:
  - On each edge with we=1: rf[wa] <= wd.
  - Exception: when ZERO_REG=1 and wa==0, the write is dropped. This does not pulse wr_drop.
  - wr_drop <= 0 in RUN.
- Read data, combinational, per port i:
  - state==CLEAR -> 0.
  - else ZERO_REG=1 and rs_i==0 -> 0.
  - else BYPASS=1 and we=1 and wa==rs_i (and not the zero-register case) -> wd.
  - else rf[rs_i].
  - Read latency is 0 cycles. Every port is decoded independently against its own address; there is no cross-port aliasing.
- Multiple ports may read the same address in the same cycle; all return identical data.
- With BYPASS=0, data written at edge N is visible on reads after edge N only (read-old-value within the cycle).
- Reset asserted mid-CLEAR restarts the clear from index 0. Reset asserted in RUN re-enters CLEAR and re-zeroes the whole file.
- clr_idx wraps naturally; the RUN transition is taken on the DEPTH-1 compare, so no extra cycle is spent.
- No X may propagate to rdata after ready=1, including for entries never written.

Test Plan:
- Clear timing: assert rst for 3 cycles, release. ready stays 0 for 31 edges and is 1 after edge 32. Afterwards every rs in 0..31 reads 0x00000000.
- Write/read basic, BYPASS=1: write wa=5, wd=0xDEADBEEF with rs0=5 in the same cycle -> rdata0=0xDEADBEEF combinationally. After the edge with we=0 -> still 0xDEADBEEF.
- Zero register: write wa=0, wd=0xFFFFFFFF, then read rs0=0, rs1=0 -> both 0. wr_drop stays 0.
- Write during clear: we=1, wa=7, wd=0x12345678 on the 4th edge after reset release.
  - Required: wr_drop=1 for exactly one cycle.
  - Required: after ready, rs0=7 reads 0.
- Mid-clear reset: release rst, wait 10 edges, pulse rst for 1 cycle. ready rises exactly 32 edges after the second release; no entry is non-zero.
- Multi-port, NUM_READ=3, BYPASS=0:
  - Preload x1=0x11, x2=0x22.
  - Same cycle: rs={1,2,1} with we=1, wa=1, wd=0x99 -> rdata={0x11,0x22,0x11}.
  - Next cycle -> {0x99,0x22,0x99}.
